// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: FSM state
// encoding, PC increment and the default program ROM word-address width.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  localparam int ROM_AW = 6;

endpackage

// File: rtl/fetch_sat_counter.sv
// Saturating up-counter used to tally delivered instructions.
// Only reset clears it; it sticks at all-ones once full.
module fetch_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Count up on each request, stopping at the all-ones value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the program ROM,
// and registers the returned word into an instruction register for decode.
// Supports decode stall, branch redirect with squash, and halting once the
// PC walks past the last program word.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          PROG_WORDS = 12,
  parameter int          ROM_AW     = 6,
  parameter int          CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [31:0]       branch_target,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [31:0]       ir,
  output logic [31:0]       ir_pc,
  output logic              ir_valid,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  import fetch_pkg::*;

  // Word-index limit compared against pc[31:2] so high addresses halt
  // instead of aliasing onto the small ROM.
  localparam logic [29:0] PROG_LIMIT = 30'(PROG_WORDS);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  ir_n, ir_pc_n;
  logic         ir_valid_n;
  logic         count_inc;

  assign rom_addr = pc[ROM_AW+1:2];
  assign busy     = (state == RUN);
  assign halted   = (state == HALT);

  // State, PC and instruction register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ir_pc    <= ir_pc_n;
      ir_valid <= ir_valid_n;
    end
  end

  // Next-state logic; in RUN a branch beats a stall, and the end-of-program
  // check only happens on unstalled cycles.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ir_n       = ir;
    ir_pc_n    = ir_pc;
    ir_valid_n = ir_valid;
    count_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        ir_valid_n = 1'b0;
        if (start) begin
          state_n = RUN;
          pc_n    = RESET_PC;
        end
      end
      RUN: begin
        if (branch_valid) begin
          pc_n       = branch_target & ~32'h3;
          ir_valid_n = 1'b0;
        end else if (stall) begin
          pc_n = pc;
        end else if (pc[31:2] >= PROG_LIMIT) begin
          state_n    = HALT;
          ir_valid_n = 1'b0;
        end else begin
          ir_n       = rom_data;
          ir_pc_n    = pc;
          ir_valid_n = 1'b1;
          pc_n       = pc + PC_STEP;
          count_inc  = 1'b1;
        end
      end
      HALT: begin
        ir_valid_n = 1'b0;
        if (start) begin
          state_n = RUN;
          pc_n    = RESET_PC;
        end
      end
      default: begin
        state_n    = IDLE;
        ir_valid_n = 1'b0;
      end
    endcase
  end

  fetch_sat_counter #(
    .CNT_W(CNT_W)
  ) u_count (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (count_inc),
    .count(fetch_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a falling-edge
// registered program ROM model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        branch_valid;
  logic [31:0] branch_target;
  logic [5:0]  rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        busy;
  logic        halted;
  logic [15:0] fetch_count;

  logic [31:0] rom [64];

  int compared   = 0;
  int mismatched = 0;

  fetch_sequencer #(
    .RESET_PC  (32'h0),
    .PROG_WORDS(12),
    .ROM_AW    (6),
    .CNT_W     (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stall        (stall),
    .branch_valid (branch_valid),
    .branch_target(branch_target),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid),
    .busy         (busy),
    .halted       (halted),
    .fetch_count  (fetch_count)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Program ROM registers its read on the falling edge.
  always @(negedge clk) rom_data <= rom[rom_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's worth of inputs, advance past the next rising edge.
  task automatic applyStimulus(input logic st, input logic sl, input logic bv,
                               input logic [31:0] bt);
    start         = st;
    stall         = sl;
    branch_valid  = bv;
    branch_target = bt;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rom[0]  = 32'h13a0000c;
    rom[1]  = 32'he3a01004;
    rom[2]  = 32'he0812000;
    rom[3]  = 32'he2511001;
    rom[4]  = 32'h1afffffc;
    rom[5]  = 32'he3a03010;
    rom[6]  = 32'he0834002;
    rom[7]  = 32'he1a05004;
    rom[8]  = 32'he2455001;
    rom[9]  = 32'he3550000;
    rom[10] = 32'h1afffffc;
    rom[11] = 32'he1016090;
    for (int i = 12; i < 64; i++) rom[i] = 32'hbad00000 | 32'(i);

    rst_n = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    branch_valid = 1'b0;
    branch_target = 32'h0;
    #12;
    checkOutput("rst_busy",     {31'b0, busy},     32'h0);
    checkOutput("rst_halted",   {31'b0, halted},   32'h0);
    checkOutput("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("rst_ir",       ir,                32'h0);
    checkOutput("rst_ir_pc",    ir_pc,             32'h0);
    checkOutput("rst_count",    {16'b0, fetch_count}, 32'h0);
    checkOutput("rst_rom_addr", {26'b0, rom_addr}, 32'h0);
    rst_n = 1'b1;

    // IDLE ignores stall and branch
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h20);
    checkOutput("idle_busy",     {31'b0, busy},     32'h0);
    checkOutput("idle_rom_addr", {26'b0, rom_addr}, 32'h0);

    // Free run: start, then 12 valid words, then halt
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("start_busy",  {31'b0, busy},     32'h1);
    checkOutput("start_valid", {31'b0, ir_valid}, 32'h0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput($sformatf("run_ir%0d", i),    ir,    rom[i]);
      checkOutput($sformatf("run_pc%0d", i),    ir_pc, 32'(4 * i));
      checkOutput($sformatf("run_valid%0d", i), {31'b0, ir_valid}, 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("end_halted", {31'b0, halted},   32'h1);
    checkOutput("end_valid",  {31'b0, ir_valid}, 32'h0);
    checkOutput("end_count",  {16'b0, fetch_count}, 32'd12);
    checkOutput("end_ir",     ir,    32'he1016090);
    checkOutput("end_ir_pc",  ir_pc, 32'd44);

    // HALT ignores stall and branch; PC holds at word 12
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h8);
    checkOutput("halt_halted",   {31'b0, halted},   32'h1);
    checkOutput("halt_rom_addr", {26'b0, rom_addr}, 32'd12);
    checkOutput("halt_ir_pc",    ir_pc,             32'd44);

    // Restart from HALT: PC back to RESET_PC, count keeps going
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("restart_busy",     {31'b0, busy},     32'h1);
    checkOutput("restart_rom_addr", {26'b0, rom_addr}, 32'h0);
    checkOutput("restart_valid",    {31'b0, ir_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("restart_ir",    ir,    32'h13a0000c);
    checkOutput("restart_ir_pc", ir_pc, 32'h0);
    checkOutput("restart_count", {16'b0, fetch_count}, 32'd13);
    // start while running is ignored
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("run_start_ir",    ir,    32'he3a01004);
    checkOutput("run_start_ir_pc", ir_pc, 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("pre_stall_ir_pc", ir_pc, 32'h8);

    // Stall for 3 cycles holding ir_pc=8 and rom_addr=3
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput($sformatf("stall_ir%0d", k),    ir,    rom[2]);
      checkOutput($sformatf("stall_ir_pc%0d", k), ir_pc, 32'h8);
      checkOutput($sformatf("stall_addr%0d", k),  {26'b0, rom_addr}, 32'd3);
      checkOutput($sformatf("stall_valid%0d", k), {31'b0, ir_valid}, 32'h1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("post_stall_ir",    ir,    rom[3]);
    checkOutput("post_stall_ir_pc", ir_pc, 32'd12);
    checkOutput("post_stall_addr",  {26'b0, rom_addr}, 32'd4);

    // Branch with simultaneous stall: branch wins, word squashed
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h6);
    checkOutput("br_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("br_addr",  {26'b0, rom_addr}, 32'd1);
    checkOutput("br_count", {16'b0, fetch_count}, 32'd16);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("br_ir",    ir,    32'he3a01004);
    checkOutput("br_ir_pc", ir_pc, 32'h4);
    checkOutput("br_count2", {16'b0, fetch_count}, 32'd17);

    // Out-of-range branch: one squash cycle then HALT
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    checkOutput("oor_valid",  {31'b0, ir_valid}, 32'h0);
    checkOutput("oor_busy",   {31'b0, busy},     32'h1);
    checkOutput("oor_addr",   {26'b0, rom_addr}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("oor_halted", {31'b0, halted},   32'h1);
    checkOutput("oor_count",  {16'b0, fetch_count}, 32'd17);
    checkOutput("oor_ir_pc",  ir_pc, 32'h4);

    // Async reset mid-run, between clock edges
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("pre_rst_count", {16'b0, fetch_count}, 32'd18);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'b0, ir_valid}, 32'h0);
    checkOutput("arst_busy",  {31'b0, busy},     32'h0);
    checkOutput("arst_ir",    ir,                32'h0);
    checkOutput("arst_ir_pc", ir_pc,             32'h0);
    checkOutput("arst_count", {16'b0, fetch_count}, 32'h0);
    checkOutput("arst_addr",  {26'b0, rom_addr}, 32'h0);
    #2;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("after_rst_ir",    ir,    32'h13a0000c);
    checkOutput("after_rst_ir_pc", ir_pc, 32'h0);
    checkOutput("after_rst_count", {16'b0, fetch_count}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that sequences the 64x32 program ROM (6-bit word address, registered read on falling clock edge) for the CPU core.
- Owns the PC and drives the ROM address, then registers the returned word into an instruction register with a valid flag for decode.
- Handles stall, branch redirect with squash, and halting at end of program.
- Sits between the program ROM and the decode stage; one instruction per cycle, 1-cycle fetch latency.

Parameters:
- RESET_PC, 32'h0, byte address loaded into PC at reset and on start.
- PROG_WORDS, 12, number of valid program words; a word index >= PROG_WORDS ends execution.
- ROM_AW, 6, ROM word-address width.
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; IDLE/HALT -> RUN, PC reloaded to RESET_PC.
- stall  in  1  hold the fetch pipeline (decode back-pressure).
- branch_valid  in  1  redirect request.
- branch_target  in  32  redirect byte address; bits [1:0] forced to 0.
- rom_addr  out  ROM_AW  = pc[ROM_AW+1:2], combinational from the PC register.
- rom_data  in  32  ROM output, valid from the falling edge after rom_addr settles.
- ir  out  32  fetched instruction.
- ir_pc  out  32  byte address of ir.
- ir_valid  out  1  ir holds a live instruction.
- busy  out  1  state == RUN.
- halted  out  1  state == HALT.
- fetch_count  out  CNT_W  valid instructions delivered, saturating.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, fetch_count=0. Consequently busy=0 and halted=0.
- Timing: pc=A at rising edge N drives rom_addr. The ROM captures on the falling edge in cycle N. At rising edge N+1, ir<=rom_data, ir_pc<=A, ir_valid<=1, pc<=A+4.
- IDLE:
  - rom_addr is driven; ir_valid=0; stall and branch are ignored.
  - start -> RUN, with pc<=RESET_PC.
- RUN, evaluated at each rising edge in this priority:
  - 1. branch_valid: pc<={branch_target[31:2],2'b00}; ir_valid<=0, squashing the in-flight word. This applies even if stall=1.
  - 2. stall: pc, ir, ir_pc and ir_valid hold. rom_addr is unchanged, so the ROM re-reads the same word.
  - 3. pc word index >= PROG_WORDS: -> HALT, ir_valid<=0, pc holds.
  - 4. otherwise: normal fetch as described under Timing.
- A branch to an out-of-range target is accepted; the next unstalled cycle detects it and halts.
- A stalled cycle never halts; the end check happens only when not stalled.
- HALT:
  - ir_valid=0; ir and ir_pc hold their last values.
  - branch and stall are ignored.
  - start -> RUN with pc<=RESET_PC. fetch_count is not cleared; only reset clears it.
- start while in RUN is ignored.
- fetch_count increments on every rising edge where ir_valid is set to 1 by a normal fetch, and saturates at all-ones.
- PC arithmetic is 32-bit modulo; only bits [ROM_AW+1:2] reach the ROM. Index comparison uses pc[31:2] so high addresses halt rather than alias.

Decomposition:
- Shared package fetch_pkg:
  - state encoding IDLE=2'd0, RUN=2'd1, HALT=2'd2;
  - PC_STEP=32'd4;
  - ROM word-index helper constant ROM_AW=6.
- One sub-module, fetch_sat_counter: CNT_W saturating counter with inc and async clear. The FSM, PC and IR stay in fetch_sequencer.

Test Plan:
- Reset then start with the program image loaded (word0=32'h13a0000c, word1=32'he3a01004). Required: one cycle after start, ir=32'h13a0000c, ir_pc=0, ir_valid=1. Next cycle ir=32'he3a01004, ir_pc=4.
- Run free with no stall. Required: 12 valid words are delivered, with word11=32'he1016090 at ir_pc=44. The next cycle gives halted=1, ir_valid=0, fetch_count=12.
- Assert stall for 3 cycles with ir_pc=8. Required: ir, ir_pc=8 and rom_addr=3 hold for 3 cycles. After stall release, ir_pc=12 follows with no duplicate and no skip.
- Branch while at pc=16: branch_valid=1 with target 32'h6 and stall=1 in the same cycle. Required: the next cycle has ir_valid=0 and pc=4. The following cycle gives ir=32'he3a01004, ir_pc=4.
- Out-of-range branch, target 32'h100. Required: 1 squash cycle, then HALT. Any fetch_count increment is only from earlier valid fetches.
- Mid-run: assert rst_n=0 asynchronously between clock edges. Required: outputs go to reset values immediately. Then start from HALT and confirm a restart at RESET_PC with fetch_count continuing (no reset only).
